load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-organised on-chip RAM.
- Accepts one byte, halfword or word load/store request at a time and converts it into a word-aligned RAM access with byte strobes.
- For loads, waits out the RAM's one-cycle read latency, then extracts and sign- or zero-extends the addressed lane.
- Rejects misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
- RAM_BYTES, 63488: size of the RAM address space in bytes. Byte addresses >= RAM_BYTES fault.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads only: zero-extend (1) or sign-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  2  0 = ok, 1 = misaligned, 2 = out of range, 3 = illegal size.
- mem_addr  out  32  word-aligned byte address to RAM (bits [1:0] always 0).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte write strobes.
- mem_rdata  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset (async assert, sync deassert on next clk edge): state IDLE. All registered outputs reset to 0: mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata, rsp_fault. req_ready is 1 after reset.
- State machine: IDLE, ISSUE, LOAD, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on the edge where req_valid && req_ready.
  - Fault check, in priority order: size==3 -> fault 3; misaligned -> fault 1 (half with addr[0]!=0, or word with addr[1:0]!=0); addr >= RAM_BYTES -> fault 2.
  - On a fault: go to RESP with the fault code and rsp_rdata = 0. Memory is never driven (mem_wstrb stays 0).
  - Otherwise: register the request; drive mem_addr = {addr[31:2], 2'b00}; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_addr stable.
  - Store: mem_wstrb = byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111. mem_wdata = byte replicated x4, half replicated x2, word as-is. Next state RESP, fault 0, rsp_rdata 0.
  - Load: mem_wstrb = 0. Next state LOAD.
- LOAD (one cycle): mem_rdata is valid.
  - Select lane: byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1].
  - Extend per req_unsigned.
  - Register the result into rsp_rdata; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_fault held stable.
  - On rsp_ready, go to IDLE.
  - rsp_ready may already be high on the first RESP cycle.
  - No new request is accepted in the same cycle as the response handshake.
- mem_wstrb is nonzero only during ISSUE for stores. mem_addr holds its last value outside ISSUE.
- Latency from the accept edge to rsp_valid: load 3 cycles, store 2, fault 1.
- Reset mid-operation: everything returns to reset values immediately. A store in ISSUE may or may not have committed; the bench must not check that write.

Decomposition:
- lsu_pkg holds:
  - enum size_e (BYTE, HALF, WORD, ILLEGAL);
  - enum fault_e (NONE, MISALIGNED, RANGE, ILLEGAL_SIZE);
  - enum state_e (IDLE, ISSUE, LOAD, RESP).
- Sub-module lsu_align (combinational):
  - inputs size, addr[1:0], unsigned, wdata, rdata;
  - outputs wstrb, lane-replicated wdata, extended load data.
- The top module keeps the FSM and registers.

Test Plan:
1. Word store then load: store addr 0x10, data 0xDEADBEEF, size 2 -> mem_wstrb 4'b1111 for exactly one cycle, rsp_valid 2 cycles after accept. Load 0x10 -> rsp_rdata 0xDEADBEEF, 3 cycles after accept, fault 0.
2. Byte lanes: store byte 0x80 to 0x13 -> mem_wstrb 4'b1000, mem_wdata 0x80808080. Signed byte load from 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
3. Halfword: store 0x8001 to 0x22 -> wstrb 4'b1100. Signed half load from 0x22 -> 0xFFFF8001. Half load from 0x21 -> fault 1, 1-cycle latency, mem_wstrb never nonzero.
4. Range and illegal size: load at 63488 -> fault 2. Store with size 3 to addr 0x3 -> fault 3 (illegal size wins over misalignment). No strobe is asserted in either case.
5. Response backpressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready -> IDLE the next cycle, and the next request is accepted.
6. Reset mid-load: deassert rst_n during LOAD -> rsp_valid, mem_wstrb and req_ready go to 0/0/1 asynchronously. After release, a fresh word load returns correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// Request size, fault code and FSM state encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        MISALIGNED   = 2'd1,
        RANGE        = 2'd2,
        ILLEGAL_SIZE = 2'd3
    } fault_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Illegal size outranks misalignment, which outranks range.
    function automatic fault_e check_req(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] limit
    );
        if (size == 2'd3)
            return ILLEGAL_SIZE;
        if ((size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00))
            return MISALIGNED;
        if (addr >= limit)
            return RANGE;
        return NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Builds store strobes/replicated data and extends load lanes.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        byte_v    = rdata[{addr, 3'b000} +: 8];
        half_v    = rdata[{addr[1], 4'b0000} +: 16];
        unique case (size)
            BYTE: begin
                wstrb     = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = zext ? {24'b0, byte_v}
                                 : {{24{byte_v[7]}}, byte_v};
            end
            HALF: begin
                wstrb     = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = zext ? {16'b0, half_v}
                                 : {{16{half_v[15]}}, half_v};
            end
            WORD: begin
                wstrb = 4'b1111;
            end
            default: begin
                wstrb = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and word-organised RAM.
// One request in flight; loads wait out the RAM read latency.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 32'd63488
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    state_e     state, state_n;
    logic       q_write;
    logic       q_zext;
    size_e      q_size;
    logic [1:0] q_lo;
    fault_e     req_flt;
    logic       accept;

    size_e       al_size;
    logic [1:0]  al_addr;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_flt   = check_req(req_size, req_addr, RAM_BYTES);

    // Steer the live request while idle, the latched one afterwards.
    assign al_size = req_ready ? size_e'(req_size) : q_size;
    assign al_addr = req_ready ? req_addr[1:0] : q_lo;

    lsu_align u_align (
        .size      (al_size),
        .addr      (al_addr),
        .zext      (q_zext),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .wstrb     (al_wstrb),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept)
                         state_n = (req_flt != NONE) ? RESP : ISSUE;
            ISSUE:   state_n = q_write ? RESP : LOAD;
            LOAD:    state_n = RESP;
            RESP:    if (rsp_ready)
                         state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_write   <= 1'b0;
            q_zext    <= 1'b0;
            q_size    <= BYTE;
            q_lo      <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_flt != NONE) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= req_flt;
                            rsp_rdata <= '0;
                        end else begin
                            q_write  <= req_write;
                            q_zext   <= req_unsigned;
                            q_size   <= size_e'(req_size);
                            q_lo     <= req_addr[1:0];
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_write) begin
                                mem_wstrb <= al_wstrb;
                                mem_wdata <= al_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    mem_wstrb <= '0;
                    if (q_write) begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= NONE;
                        rsp_rdata <= '0;
                    end
                end
                LOAD: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= NONE;
                    rsp_rdata <= al_rdata;
                end
                RESP: begin
                    if (rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Byte-array reference model plus a one-cycle-latency RAM model.
module tb_load_store_unit;

    localparam int RAM_BYTES = 63488;
    localparam int NWORDS    = RAM_BYTES / 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] ram     [NWORDS];
    logic [7:0]  ref_mem [RAM_BYTES];

    load_store_unit #(.RAM_BYTES(RAM_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: synchronous read, byte-strobed write.
    always @(posedge clk) begin
        if (int'(mem_addr[31:2]) < NWORDS) begin
            for (int i = 0; i < 4; i++)
                if (mem_wstrb[i])
                    ram[mem_addr[31:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            mem_rdata <= ram[mem_addr[31:2]];
        end else begin
            mem_rdata <= 32'hBAD0BAD0;
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [1:0] model_fault(input logic [1:0] sz,
                                               input logic [31:0] a);
        if (sz == 2'd3)
            return 2'd3;
        if ((a % nbytes(sz)) != 0)
            return 2'd1;
        if (a >= RAM_BYTES)
            return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz,
                                               input logic uns,
                                               input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = '0;
        for (int k = 0; k < n; k++)
            v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (n < 4 && !uns && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz,
                                              input logic [31:0] a);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < nbytes(sz); k++)
            m[(a % 4) + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz,
                                                input logic [31:0] d);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b < 4; b++)
            v[8*b +: 8] = d[8*(b % nbytes(sz)) +: 8];
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] d);
        for (int k = 0; k < nbytes(sz); k++)
            ref_mem[a + k] = d[8*k +: 8];
    endtask

    // Issue one request; leaves the unit in RESP with rsp_ready low.
    task automatic run_req(input logic w, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a,
                           input logic [31:0] wd,
                           output logic [31:0] rd, output logic [1:0] flt,
                           output int lat, output int nstrb,
                           output logic [3:0] strb, output logic [31:0] wseen,
                           output logic rdy);
        @(negedge clk);
        rdy          = req_ready;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        lat   = 0;
        nstrb = 0;
        strb  = '0;
        wseen = '0;
        do begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            lat++;
            if (mem_wstrb != 4'b0000) begin
                nstrb++;
                strb  = mem_wstrb;
                wseen = mem_wdata;
            end
        end while (!rsp_valid && lat < 20);
        rd  = rsp_rdata;
        flt = rsp_fault;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_wstrb !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctl: ready=%b valid=%b wstrb=%b, need 1 0 0",
                     req_ready, rsp_valid, mem_wstrb);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_mem: addr=%h wdata=%h, need 0 0", mem_addr, mem_wdata);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_fault !== 2'd0) begin
            fails++;
            $display("FAIL reset_rsp: rdata=%h fault=%0d, need 0 0", rsp_rdata, rsp_fault);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, ws;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, f, lat, ns, st, ws, rdy);
        model_store(2'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if (ns != 1 || st !== 4'b1111 || lat != 2 || f !== 2'd0) begin
            fails++;
            $display("FAIL word_store: nstrb=%0d strb=%b lat=%0d fault=%0d, need 1 1111 2 0",
                     ns, st, lat, f);
        end
        finish_rsp();
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rd !== model_load(2'd2, 1'b0, 32'h10) || rd !== 32'hDEADBEEF ||
            lat != 3 || f !== 2'd0 || ns != 0) begin
            fails++;
            $display("FAIL word_load: rdata=%h lat=%0d fault=%0d nstrb=%0d, need deadbeef 3 0 0",
                     rd, lat, f, ns);
        end
        finish_rsp();
    endtask

    task automatic test_byte();
        logic [31:0] rd, ws;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd, f, lat, ns, st, ws, rdy);
        model_store(2'd0, 32'h13, 32'h80);
        checks++;
        if (st !== 4'b1000 || ws !== 32'h80808080 || ns != 1 || lat != 2) begin
            fails++;
            $display("FAIL byte_store: strb=%b wdata=%h nstrb=%0d lat=%0d, need 1000 80808080 1 2",
                     st, ws, ns, lat);
        end
        finish_rsp();
        run_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rd !== 32'hFFFFFF80 || rd !== model_load(2'd0, 1'b0, 32'h13)) begin
            fails++;
            $display("FAIL byte_load_s: rdata=%h, need ffffff80", rd);
        end
        finish_rsp();
        run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rd !== 32'h00000080 || f !== 2'd0) begin
            fails++;
            $display("FAIL byte_load_u: rdata=%h fault=%0d, need 00000080 0", rd, f);
        end
        finish_rsp();
    endtask

    task automatic test_half();
        logic [31:0] rd, ws;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        run_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, rd, f, lat, ns, st, ws, rdy);
        model_store(2'd1, 32'h22, 32'h8001);
        checks++;
        if (st !== 4'b1100 || ws !== 32'h80018001 || ns != 1) begin
            fails++;
            $display("FAIL half_store: strb=%b wdata=%h nstrb=%0d, need 1100 80018001 1",
                     st, ws, ns);
        end
        finish_rsp();
        run_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rd !== 32'hFFFF8001 || lat != 3) begin
            fails++;
            $display("FAIL half_load: rdata=%h lat=%0d, need ffff8001 3", rd, lat);
        end
        finish_rsp();
        run_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (f !== 2'd1 || lat != 1 || ns != 0 || rd !== 32'h0) begin
            fails++;
            $display("FAIL half_misalign: fault=%0d lat=%0d nstrb=%0d rdata=%h, need 1 1 0 0",
                     f, lat, ns, rd);
        end
        finish_rsp();
    endtask

    task automatic test_range_illegal();
        logic [31:0] rd, ws;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        run_req(1'b0, 2'd2, 1'b0, 32'(RAM_BYTES), 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (f !== 2'd2 || lat != 1 || ns != 0 || rd !== 32'h0) begin
            fails++;
            $display("FAIL range: fault=%0d lat=%0d nstrb=%0d rdata=%h, need 2 1 0 0",
                     f, lat, ns, rd);
        end
        finish_rsp();
        run_req(1'b1, 2'd3, 1'b0, 32'h3, 32'h55, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (f !== 2'd3 || lat != 1 || ns != 0) begin
            fails++;
            $display("FAIL illegal: fault=%0d lat=%0d nstrb=%0d, need 3 1 0", f, lat, ns);
        end
        finish_rsp();
        run_req(1'b0, 2'd2, 1'b0, 32'(RAM_BYTES - 4), 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (f !== 2'd0 || lat != 3 || rd !== model_load(2'd2, 1'b0, 32'(RAM_BYTES - 4))) begin
            fails++;
            $display("FAIL last_word: fault=%0d lat=%0d rdata=%h, need 0 3 %h",
                     f, lat, rd, model_load(2'd2, 1'b0, 32'(RAM_BYTES - 4)));
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, ws, d, exp;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        d = $urandom;
        run_req(1'b1, 2'd2, 1'b0, 32'h30, d, rd, f, lat, ns, st, ws, rdy);
        model_store(2'd2, 32'h30, d);
        finish_rsp();
        exp = model_load(2'd2, 1'b0, 32'h30);
        run_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, f, lat, ns, st, ws, rdy);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: valid=%b rdata=%h ready=%b, need 1 %h 0",
                         i, rsp_valid, rsp_rdata, req_ready, exp);
            end
        end
        finish_rsp();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL release: ready=%b valid=%b, need 1 0", req_ready, rsp_valid);
        end
        run_req(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rdy !== 1'b1 || rd !== model_load(2'd0, 1'b1, 32'h31) || lat != 3) begin
            fails++;
            $display("FAIL after_bp: ready=%b rdata=%h lat=%0d, need 1 %h 3",
                     rdy, rd, lat, model_load(2'd0, 1'b1, 32'h31));
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] rd, ws;
        logic [1:0]  f;
        logic [3:0]  st;
        logic        rdy;
        int          lat, ns;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mem_wstrb !== 4'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: valid=%b wstrb=%b ready=%b, need 0 0 1",
                     rsp_valid, mem_wstrb, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, f, lat, ns, st, ws, rdy);
        checks++;
        if (rd !== model_load(2'd2, 1'b0, 32'h10) || f !== 2'd0 || lat != 3) begin
            fails++;
            $display("FAIL post_reset_load: rdata=%h fault=%0d lat=%0d, need %h 0 3",
                     rd, f, lat, model_load(2'd2, 1'b0, 32'h10));
        end
        finish_rsp();
    endtask

    task automatic test_random();
        logic [31:0] rd, ws, a, d, exp_rd;
        logic [1:0]  f, sz, exp_f;
        logic [3:0]  st;
        logic        rdy, w, uns;
        int          lat, ns, r, exp_lat, exp_ns;
        for (int it = 0; it < 60; it++) begin
            r   = $urandom_range(0, 9);
            sz  = (r == 9) ? 2'd3 : 2'(r / 3);
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            d   = $urandom;
            if ($urandom_range(0, 7) == 0)
                a = 32'(RAM_BYTES - 4 + $urandom_range(0, 7));
            else
                a = 32'($urandom_range(0, 63));
            exp_f   = model_fault(sz, a);
            exp_lat = (exp_f != 2'd0) ? 1 : (w ? 2 : 3);
            exp_ns  = (exp_f == 2'd0 && w) ? 1 : 0;
            exp_rd  = (exp_f == 2'd0 && !w) ? model_load(sz, uns, a) : 32'h0;
            run_req(w, sz, uns, a, d, rd, f, lat, ns, st, ws, rdy);
            if (exp_f == 2'd0 && w)
                model_store(sz, a, d);
            checks++;
            if (f !== exp_f || rd !== exp_rd || lat != exp_lat || ns != exp_ns) begin
                fails++;
                $display("FAIL rand_%0d w=%b sz=%0d a=%h: fault=%0d rdata=%h lat=%0d nstrb=%0d, need %0d %h %0d %0d",
                         it, w, sz, a, f, rd, lat, ns, exp_f, exp_rd, exp_lat, exp_ns);
            end
            if (exp_ns == 1) begin
                checks++;
                if (st !== model_strb(sz, a) || ws !== model_wdata(sz, d)) begin
                    fails++;
                    $display("FAIL rand_strb_%0d: strb=%b wdata=%h, need %b %h",
                             it, st, ws, model_strb(sz, a), model_wdata(sz, d));
                end
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            finish_rsp();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++)
            ram[i] = '0;
        for (int i = 0; i < RAM_BYTES; i++)
            ref_mem[i] = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_range_illegal();
        test_backpressure();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
